// File: rtl/mud_wl_ctrl.sv
// Two-port wordline access sequencer: precharge -> wordline -> sense/write -> recovery.
// Define MUD_WL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches addr/wr/grant
// PRE   | bitline precharge, T_PRE cycles
// WL    | wordline asserted, settling for T_WL cycles
// ACT   | one cycle of sense-amp (read) or write-driver (write) strobe
// REC   | wordline dropped, T_REC recovery cycles; ack on the last one
module mud_wl_ctrl #(
    parameter int unsigned T_PRE = 2,
    parameter int unsigned T_WL  = 2,
    parameter int unsigned T_REC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] addr0,
    input  logic [2:0] addr1,
    input  logic       wr0,
    input  logic       wr1,
    output logic       ack0,
    output logic       ack1,
    output logic       dec_enb,
    output logic [2:0] dec_addr,
    output logic       pre_en,
    output logic       sae,
    output logic       wen,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WL,
        S_ACT,
        S_REC
    } state_t;

    localparam logic [3:0] PRE_LD = 4'(T_PRE - 1);
    localparam logic [3:0] WL_LD  = 4'(T_WL - 1);
    localparam logic [3:0] REC_LD = 4'(T_REC - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] addr_q, addr_nx;
    logic       wr_q, wr_nx;
    logic       gnt_q, gnt_nx;
    logic       win;

`ifdef MUD_WL_RR_EN
    logic last_q;

    // On a tie the port not granted last wins; a lone request always wins.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state == S_IDLE && (req0 || req1)) begin
            last_q <= win;
        end
    end
`else
    assign win = ~req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            addr_q <= 3'd0;
            wr_q   <= 1'b0;
            gnt_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            addr_q <= addr_nx;
            wr_q   <= wr_nx;
            gnt_q  <= gnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        wr_nx    = wr_q;
        gnt_nx   = gnt_q;
        pre_en   = 1'b0;
        dec_enb  = 1'b0;
        sae      = 1'b0;
        wen      = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        busy     = (state != S_IDLE);
        dec_addr = addr_q;
        unique case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_nx   = win;
                    addr_nx  = win ? addr1 : addr0;
                    wr_nx    = win ? wr1 : wr0;
                    cnt_nx   = PRE_LD;
                    state_nx = S_PRE;
                end
            end
            S_PRE: begin
                pre_en = 1'b1;
                if (cnt == 4'd0) begin
                    cnt_nx   = WL_LD;
                    state_nx = S_WL;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_WL: begin
                dec_enb = 1'b1;
                if (cnt == 4'd0) begin
                    state_nx = S_ACT;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ACT: begin
                dec_enb  = 1'b1;
                sae      = ~wr_q;
                wen      = wr_q;
                cnt_nx   = REC_LD;
                state_nx = S_REC;
            end
            S_REC: begin
                if (cnt == 4'd0) begin
                    ack0     = ~gnt_q;
                    ack1     = gnt_q;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mud_wl_ctrl.sv
// Bench for mud_wl_ctrl: two instances (default timing and T_PRE=1/T_WL=3/T_REC=2)
// checked every cycle against an offset-within-access reference model.
module tb_mud_wl_ctrl;

    localparam int TP [2] = '{2, 1};
    localparam int TW [2] = '{2, 3};
    localparam int TR [2] = '{1, 2};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] req  [2];
    logic [1:0] wr   [2];
    logic [2:0] addr [2][2];
    logic       ack0 [2];
    logic       ack1 [2];
    logic       dec_enb [2];
    logic [2:0] dec_addr [2];
    logic       pre_en [2];
    logic       sae [2];
    logic       wen [2];
    logic       busy [2];

    mud_wl_ctrl dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0][0]), .req1(req[0][1]),
        .addr0(addr[0][0]), .addr1(addr[0][1]),
        .wr0(wr[0][0]), .wr1(wr[0][1]),
        .ack0(ack0[0]), .ack1(ack1[0]),
        .dec_enb(dec_enb[0]), .dec_addr(dec_addr[0]),
        .pre_en(pre_en[0]), .sae(sae[0]), .wen(wen[0]), .busy(busy[0])
    );

    mud_wl_ctrl #(.T_PRE(1), .T_WL(3), .T_REC(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req[1][0]), .req1(req[1][1]),
        .addr0(addr[1][0]), .addr1(addr[1][1]),
        .wr0(wr[1][0]), .wr1(wr[1][1]),
        .ack0(ack0[1]), .ack1(ack1[1]),
        .dec_enb(dec_enb[1]), .dec_addr(dec_addr[1]),
        .pre_en(pre_en[1]), .sae(sae[1]), .wen(wen[1]), .busy(busy[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: an access is tracked by its cycle offset k from the sampling edge.
    bit m_act [2];
    int m_k   [2];
    int m_gp  [2];
    int m_ga  [2];
    bit m_gw  [2];
`ifdef MUD_WL_RR_EN
    int m_last [2];
`endif

    function automatic int tot(input int i);
        return TP[i] + TW[i] + 1 + TR[i];
    endfunction

    function automatic bit exp_ack(input int i, input int p);
        return m_act[i] && m_k[i] == tot(i) && m_gp[i] == p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
`ifdef MUD_WL_RR_EN
            m_last[i] = 1;
`endif
        end
    endtask

    task automatic model_step(input int i);
        int w;
        if (m_act[i]) begin
            if (m_k[i] == tot(i)) m_act[i] = 1'b0;
            else m_k[i]++;
        end else if (req[i] != 2'b00) begin
`ifdef MUD_WL_RR_EN
            if (req[i] == 2'b11) w = (m_last[i] == 0) ? 1 : 0;
            else w = req[i][1] ? 1 : 0;
            m_last[i] = w;
`else
            w = req[i][0] ? 0 : 1;
`endif
            m_act[i] = 1'b1;
            m_k[i]   = 1;
            m_gp[i]  = w;
            m_ga[i]  = int'(addr[i][w]);
            m_gw[i]  = wr[i][w];
        end
    endtask

    task automatic check_outs(input int i);
        int k;
        bit pre, enb, strb;
        logic [6:0] exp_v, obs_v;
        k    = m_k[i];
        pre  = m_act[i] && k >= 1 && k <= TP[i];
        enb  = m_act[i] && k >= TP[i] + 1 && k <= TP[i] + TW[i] + 1;
        strb = m_act[i] && k == TP[i] + TW[i] + 1;
        exp_v = {exp_ack(i, 1), exp_ack(i, 0), m_act[i], strb && m_gw[i], strb && !m_gw[i], pre, enb};
        obs_v = {ack1[i], ack0[i], busy[i], wen[i], sae[i], pre_en[i], dec_enb[i]};
        chk($sformatf("i%0d_k%0d_ack1,ack0,busy,wen,sae,pre,enb", i, k), int'(obs_v), int'(exp_v));
        if (enb) chk($sformatf("i%0d_dec_addr", i), int'(dec_addr[i]), m_ga[i]);
    endtask

    int  cyc = 0;
    int  ack_at [2];
    int  ack_cnt [2][2];
    bit  rnd_mode = 1'b0;
    bit  hold = 1'b0;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rnd_mode) begin
                    if (exp_ack(i, p) && !hold) req[i][p] = 1'b0;
                end else if (exp_ack(i, p)) begin
                    req[i][p]  = 1'($urandom_range(0, 1));
                    addr[i][p] = 3'($urandom);
                    wr[i][p]   = 1'($urandom);
                end else if (!req[i][p]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i][p]  = 1'b1;
                        addr[i][p] = 3'($urandom);
                        wr[i][p]   = 1'($urandom);
                    end
                end else begin
                    if (m_act[i] && m_gp[i] == p && $urandom_range(0, 39) == 0) req[i][p] = 1'b0;
                    if ($urandom_range(0, 7) == 0) begin
                        addr[i][p] = 3'($urandom);
                        wr[i][p]   = 1'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check_outs(i);
            if ((ack0[i] || ack1[i]) && ack_at[i] < 0) ack_at[i] = cyc;
            if (ack0[i]) ack_cnt[i][0]++;
            if (ack1[i]) ack_cnt[i][1]++;
        end
        @(negedge clk);
        drive();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_i%0d_outs", tag, i),
                int'({ack1[i], ack0[i], busy[i], wen[i], sae[i], pre_en[i], dec_enb[i]}), 0);
            chk($sformatf("%s_i%0d_dec_addr", tag, i), int'(dec_addr[i]), 0);
        end
    endtask

    task automatic set_req(input int p, input int a, input bit w);
        for (int i = 0; i < 2; i++) begin
            req[i][p]  = 1'b1;
            addr[i][p] = 3'(a);
            wr[i][p]   = w;
            ack_at[i]  = -1;
        end
    endtask

    int base;
    int n;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 2'b00;
            wr[i]  = 2'b00;
            addr[i][0] = 3'd0;
            addr[i][1] = 3'd0;
            ack_at[i] = -1;
            ack_cnt[i][0] = 0;
            ack_cnt[i][1] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        cycle();
        check_all_zero("after_release");
        run(2);

        // single read, port 0, addr 5
        set_req(0, 5, 1'b0);
        base = cyc;
        run(12);
        chk("rd_ack_cycle_a", ack_at[0] - base, 6);
        chk("rd_ack_cycle_b", ack_at[1] - base, 7);

        // single write, port 1, addr 7
        set_req(1, 7, 1'b1);
        base = cyc;
        run(12);
        chk("wr_ack_cycle_a", ack_at[0] - base, 6);
        chk("wr_ack_cycle_b", ack_at[1] - base, 7);

        // both ports held continuously
        for (int i = 0; i < 2; i++) begin
            ack_cnt[i][0] = 0;
            ack_cnt[i][1] = 0;
        end
        hold = 1'b1;
        set_req(0, 1, 1'b0);
        set_req(1, 2, 1'b0);
        run(28);
`ifdef MUD_WL_RR_EN
        chk("tie_ack0_a", ack_cnt[0][0], 2);
        chk("tie_ack1_a", ack_cnt[0][1], 2);
        chk("tie_ack0_b", ack_cnt[1][0], 2);
        chk("tie_ack1_b", ack_cnt[1][1], 1);
`else
        chk("tie_ack0_a", ack_cnt[0][0], 4);
        chk("tie_ack1_a", ack_cnt[0][1], 0);
        chk("tie_ack0_b", ack_cnt[1][0], 3);
        chk("tie_ack1_b", ack_cnt[1][1], 0);
`endif
        hold = 1'b0;
        req[0][0] = 1'b0;
        req[1][0] = 1'b0;
        ack_cnt[0][1] = 0;
        run(25);
        chk("p1_served_after_req0_drop", ack_cnt[0][1], 1);

        // address change during precharge is ignored
        set_req(0, 3, 1'b0);
        cycle();
        addr[0][0] = 3'd6;
        addr[1][0] = 3'd6;
        run(12);

        // reset asserted during WL
        set_req(0, 4, 1'b1);
        n = 0;
        while (!(m_act[0] && m_k[0] == TP[0] + 1) && n < 20) begin
            cycle();
            n++;
        end
        chk("reach_wl_bound", int'(n < 20), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_reset");
        cycle();
        rst_n = 1'b1;
        base = cyc;
        ack_at[0] = -1;
        ack_at[1] = -1;
        run(14);
        chk("post_rst_ack_cycle_a", ack_at[0] - base, 6);
        chk("post_rst_ack_cycle_b", ack_at[1] - base, 7);

        // randomized traffic
        rnd_mode = 1'b1;
        run(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mud_wl_ctrl.md
# mud_wl_ctrl

Two-port access sequencer for the 8-row wordline array. It arbitrates between two requesters (port 0, port 1) and drives the 3-to-8 wordline decoder's enable and address in a fixed precharge → wordline → sense/write → recovery sequence. It also generates the array's precharge, sense-amp and write-enable strobes. It sits between the digital access logic and the decoder/bitline periphery.

## Interface
- T_PRE, 2, precharge cycles (1..15)
- T_WL, 2, wordline settle cycles before the sense/write strobe (1..15)
- T_REC, 1, recovery cycles after wordline drop (1..15)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0, req1  input  1  access request, held high until the matching ack
- addr0, addr1  input  3  row address per port
- wr0, wr1  input  1  1 = write, 0 = read, per port
- ack0, ack1  output  1  one-cycle completion pulse per port
- dec_enb  output  1  decoder enable
- dec_addr  output  3  decoder row address
- pre_en  output  1  bitline precharge enable
- sae  output  1  sense-amp enable, reads only
- wen  output  1  write driver enable, writes only
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Reset (async, rst_n=0): state IDLE; counter 0; latched addr/wr/grant 0; last-grant pointer = port 1, so port 0 wins the first tie. All outputs are 0 during reset and on release.
- Outputs are Moore-decoded from registered state and latched fields; there are no combinational paths from inputs to outputs.
- State register: IDLE, PRE, WL, ACT, REC. Down-counter is 4 bits.
- IDLE:
  - If any req is high, select the winner, latch its addr/wr and the grant.
  - Load counter = T_PRE−1 and go to PRE.
  - Otherwise stay in IDLE.
- PRE: pre_en=1. Decrement the counter. At 0, load T_WL−1 and go to WL.
- WL: dec_enb=1, dec_addr=latched addr. At counter 0, go to ACT.
- ACT (exactly 1 cycle):
  - dec_enb=1, dec_addr held.
  - sae=1 if the latched wr=0; wen=1 if the latched wr=1.
  - Load T_REC−1 and go to REC.
- REC:
  - dec_enb=0; dec_addr holds its last value.
  - In the cycle the counter reaches 0, pulse ack of the granted port and go to IDLE.
- Arbitration: a winner is chosen only in IDLE. The loser's req stays pending and is not acknowledged.
- Inputs are sampled only in IDLE. Changes to addr/wr/req during an access have no effect on that access.
- A req dropped before its ack (protocol violation): the access still completes and ack still pulses.
- A port must not re-request in the cycle its ack is high. The IDLE cycle that follows ack sees the new req level.
- pre_en, dec_enb, sae and wen are mutually exclusive, except dec_enb with sae/wen in ACT.

## Timing
- Call the rising edge where IDLE samples req edge 0.
- pre_en is high for cycles 1..T_PRE.
- dec_enb is high for cycles T_PRE+1..T_PRE+T_WL+1, i.e. T_WL+1 cycles.
- The sae/wen strobe is in cycle T_PRE+T_WL+1.
- ack is in cycle T_PRE+T_WL+1+T_REC.
- IDLE is next; at least one IDLE cycle separates accesses.
- Back-to-back throughput: one access every T_PRE+T_WL+T_REC+2 cycles.
- Defaults: ack at cycle 6; period 7.
- Reset asserted mid-access: all outputs go to 0 immediately; no ack is issued for the aborted access; the requester must re-request.

## Configuration
- MUD_WL_RR_EN defined:
  - Round-robin arbitration. On a tie, the port not granted last wins.
  - The last-grant pointer updates on every grant.
- MUD_WL_RR_EN undefined:
  - Fixed priority, port 0 always wins a tie.
  - Port 1 is served only when req0 is low in IDLE.
  - The pointer register is removed.

## Test plan
- Reset release, then a single read from port 0 at addr 5, defaults → pre_en cycles 1–2; dec_enb=1 with dec_addr=5 in cycles 3–5; sae=1 only in cycle 5; wen never; ack0 in cycle 6; busy low in cycle 7.
- Single write from port 1 at addr 7, T_PRE=1, T_WL=3, T_REC=2 → wen=1 in cycle 5 only; sae never; ack1 in cycle 7.
- req0 and req1 held continuously, addr 1/2, MUD_WL_RR_EN defined → grants alternate 0,1,0,1; acks every 7 cycles; dec_addr alternates 1,2.
- Same stimulus, MUD_WL_RR_EN undefined → only ack0 pulses; port 1 is served only after req0 drops.
- addr0 changed from 3 to 6 during PRE → dec_addr stays 3 through ACT.
- rst_n pulsed low during WL → all outputs 0 within the reset cycle; no ack; the next request starts a fresh PRE with correct timing.
